prm_edge_mask_accum: RTL and testbench

Frame-level accumulator that sits directly upstream and downstream of the prm_oblgc_chkNNN obstacle-logic checker bank.
- Accepts a stream of 15-bit obstacle voxel codes (one obstacle cell per beat) and drives each code onto the checker bank inputs A..O.
- Samples the bank's per-edge edge_mask bits and OR-accumulates them over one frame.
- At frame end, emits the blocked-edge bitmap for the PRM graph update.

---
 rtl/prm_chk_pkg.sv | 17 +
 rtl/prm_edge_mask_accum.sv | 111 +++++++++++
 tb/tb_prm_edge_mask_accum.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/prm_chk_pkg.sv
// Shared widths, typedefs and FSM state encoding for the PRM edge-mask
// accumulator and its checker bank.
package prm_chk_pkg;

  localparam int unsigned CODE_W    = 15;
  localparam int unsigned NUM_EDGES = 16;

  typedef logic [CODE_W-1:0]    code_t;
  typedef logic [NUM_EDGES-1:0] emask_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/prm_edge_mask_accum.sv
// Frame accumulator around the obstacle-logic checker bank: registers each
// accepted code onto the bank, ORs the returned edge masks over a frame.
module prm_edge_mask_accum
  import prm_chk_pkg::*;
#(
  parameter int unsigned CODE_W    = prm_chk_pkg::CODE_W,
  parameter int unsigned NUM_EDGES = prm_chk_pkg::NUM_EDGES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 code_valid,
  output logic                 code_ready,
  input  logic [CODE_W-1:0]    code_data,
  input  logic                 code_last,
  input  logic                 frame_abort,
  output logic [CODE_W-1:0]    chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic [NUM_EDGES-1:0] mask_data,
  output logic [CNT_W-1:0]     obs_count
);

  state_t                 state;
  logic                   rdy_en;
  logic                   s1_valid;
  logic [NUM_EDGES-1:0]   acc;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   abort_en;
  logic                   release_out;

  // rdy_en keeps code_ready low until the first edge after reset release
  assign code_ready  = rdy_en && (state == ACCUM);
  assign accept      = code_valid && code_ready;
  assign abort_en    = frame_abort && (state != OUT);
  assign release_out = (state == OUT) && mask_ready;

  // Stage 1: bank input register, only updated on a kept beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en   <= 1'b0;
      chk_code <= '0;
      s1_valid <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept && !abort_en) begin
        chk_code <= code_data;
        s1_valid <= 1'b1;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: fold the bank response one cycle after chk_code changed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (abort_en || release_out) begin
      acc <= '0;
      cnt <= '0;
    end else if (s1_valid) begin
      acc <= acc | chk_mask;
      if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // DRAIN waits for the last fold to land in acc, then snapshots the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      mask_valid <= 1'b0;
      mask_data  <= '0;
      obs_count  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (!abort_en && accept && code_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_en) begin
            state <= ACCUM;
          end else if (!s1_valid) begin
            state      <= OUT;
            mask_valid <= 1'b1;
            mask_data  <= acc;
            obs_count  <= cnt;
          end
        end
        OUT: begin
          if (mask_ready) begin
            state      <= ACCUM;
            mask_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ACCUM;
          mask_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed bench for prm_edge_mask_accum with a stub checker bank.
module tb_prm_edge_mask_accum;
  import prm_chk_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid, code_ready, code_last, frame_abort;
  logic [14:0] code_data, chk_code;
  logic [15:0] chk_mask, mask_data, obs_count;
  logic        mask_valid, mask_ready;

  logic        s_valid, s_ready, s_last, s_mask_valid;
  logic [14:0] s_data, s_chk_code;
  logic [15:0] s_chk_mask, s_mask_data;
  logic [3:0]  s_obs_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] stub_bank(input logic [14:0] c);
    case (c)
      15'h4A21: return 16'h0005;
      15'h0011: return 16'h0001;
      15'h0022: return 16'h0100;
      15'h0033: return 16'hFFFF;
      15'h0044: return 16'h0002;
      default:  return 16'h0000;
    endcase
  endfunction

  assign chk_mask   = stub_bank(chk_code);
  assign s_chk_mask = stub_bank(s_chk_code);

  prm_edge_mask_accum u_dut (
    .clk(clk), .rst(rst),
    .code_valid(code_valid), .code_ready(code_ready), .code_data(code_data),
    .code_last(code_last), .frame_abort(frame_abort),
    .chk_code(chk_code), .chk_mask(chk_mask),
    .mask_valid(mask_valid), .mask_ready(mask_ready),
    .mask_data(mask_data), .obs_count(obs_count)
  );

  prm_edge_mask_accum #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .code_valid(s_valid), .code_ready(s_ready), .code_data(s_data),
    .code_last(s_last), .frame_abort(1'b0),
    .chk_code(s_chk_code), .chk_mask(s_chk_mask),
    .mask_valid(s_mask_valid), .mask_ready(1'b0),
    .mask_data(s_mask_data), .obs_count(s_obs_count)
  );

  typedef struct {
    int unsigned      n;
    logic [3:0][14:0] codes;
    logic [15:0]      exp_mask;
    logic [15:0]      exp_cnt;
  } frame_t;

  frame_t frames [4];

  function automatic frame_t mk(input int unsigned n, input logic [14:0] c0,
                                input logic [14:0] c1, input logic [14:0] c2,
                                input logic [14:0] c3, input logic [15:0] m,
                                input logic [15:0] k);
    frame_t f;
    f.n = n;
    f.codes[0] = c0; f.codes[1] = c1; f.codes[2] = c2; f.codes[3] = c3;
    f.exp_mask = m;
    f.exp_cnt  = k;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame from a negedge in ACCUM, checks latency and result.
  task automatic send_frame(input frame_t f, input bit release_res);
    int unsigned cyc;
    for (int unsigned i = 0; i < f.n; i++) begin
      check("code_ready_accum", {31'd0, code_ready}, 32'd1);
      code_valid = 1'b1;
      code_data  = f.codes[i];
      code_last  = (i == f.n - 1);
      @(negedge clk);
    end
    code_valid = 1'b0;
    code_last  = 1'b0;
    check("code_ready_drain", {31'd0, code_ready}, 32'd0);
    cyc = 0;
    while (!mask_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("mask_latency", cyc, 32'd2);
    check("code_ready_out", {31'd0, code_ready}, 32'd0);
    check("mask_data", {16'd0, mask_data}, {16'd0, f.exp_mask});
    check("obs_count", {16'd0, obs_count}, {16'd0, f.exp_cnt});
    if (release_res) begin
      mask_ready = 1'b1;
      @(negedge clk);
      mask_ready = 1'b0;
      check("mask_valid_cleared", {31'd0, mask_valid}, 32'd0);
      check("code_ready_back", {31'd0, code_ready}, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cyc;
    frames[0] = mk(1, 15'h4A21, 15'h0, 15'h0, 15'h0, 16'h0005, 16'd1);
    frames[1] = mk(3, 15'h0011, 15'h0022, 15'h0011, 15'h0, 16'h0101, 16'd3);
    frames[2] = mk(2, 15'h0022, 15'h0044, 15'h0, 15'h0, 16'h0102, 16'd2);
    frames[3] = mk(4, 15'h0011, 15'h0022, 15'h0033, 15'h0044, 16'hFFFF, 16'd4);

    rst = 1'b1;
    code_valid = 1'b0; code_data = '0; code_last = 1'b0;
    frame_abort = 1'b0; mask_ready = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;

    #3;
    check("rst_code_ready", {31'd0, code_ready}, 32'd0);
    check("rst_mask_valid", {31'd0, mask_valid}, 32'd0);
    check("rst_chk_code", {17'd0, chk_code}, 32'd0);
    check("rst_mask_data", {16'd0, mask_data}, 32'd0);
    check("rst_obs_count", {16'd0, obs_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, code_ready}, 32'd1);

    for (int k = 0; k < 4; k++) begin
      send_frame(frames[k], 1'b1);
    end

    // Backpressure in OUT with a pending producer beat
    send_frame(mk(1, 15'h0011, 15'h0, 15'h0, 15'h0, 16'h0001, 16'd1), 1'b0);
    code_valid = 1'b1; code_data = 15'h0033; code_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_code_ready", {31'd0, code_ready}, 32'd0);
      check("bp_mask_valid", {31'd0, mask_valid}, 32'd1);
      check("bp_mask_data", {16'd0, mask_data}, 32'h0001);
      check("bp_obs_count", {16'd0, obs_count}, 32'd1);
    end
    code_valid = 1'b0; code_last = 1'b0;
    mask_ready = 1'b1;
    @(negedge clk);
    mask_ready = 1'b0;
    check("bp_released", {31'd0, mask_valid}, 32'd0);
    send_frame(mk(1, 15'h0022, 15'h0, 15'h0, 15'h0, 16'h0100, 16'd1), 1'b1);

    // Abort after two beats, plus a beat dropped alongside a second abort
    for (int i = 0; i < 2; i++) begin
      code_valid = 1'b1; code_data = 15'h0033; code_last = 1'b0;
      @(negedge clk);
    end
    code_valid = 1'b0; frame_abort = 1'b1;
    @(negedge clk);
    code_valid = 1'b1; code_data = 15'h0033; code_last = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; code_last = 1'b0; frame_abort = 1'b0;
    check("abort_stays_accum", {31'd0, code_ready}, 32'd1);
    send_frame(mk(1, 15'h0044, 15'h0, 15'h0, 15'h0, 16'h0002, 16'd1), 1'b1);

    // Asynchronous reset while in DRAIN
    code_valid = 1'b1; code_data = 15'h0033; code_last = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; code_last = 1'b0;
    check("pre_rst_drain", {31'd0, code_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_mask_valid", {31'd0, mask_valid}, 32'd0);
    check("arst_chk_code", {17'd0, chk_code}, 32'd0);
    check("arst_mask_data", {16'd0, mask_data}, 32'd0);
    check("arst_obs_count", {16'd0, obs_count}, 32'd0);
    check("arst_code_ready", {31'd0, code_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_arst", {31'd0, code_ready}, 32'd1);
    send_frame(mk(1, 15'h0044, 15'h0, 15'h0, 15'h0, 16'h0002, 16'd1), 1'b1);

    // Saturating counter on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) begin
      check("sat_ready", {31'd0, s_ready}, 32'd1);
      s_valid = 1'b1; s_data = 15'h0011; s_last = (i == 19);
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    cyc = 0;
    while (!s_mask_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_latency", cyc, 32'd2);
    check("sat_mask_data", {16'd0, s_mask_data}, 32'h0001);
    check("sat_obs_count", {28'd0, s_obs_count}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
